// File: rtl/common.sv
// Shared pipeline types: control word, memory-size encodings, memory-stage state.
package common;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
  } control_type;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for data memory: byte enables, store replication,
// load lane selection with sign/zero extension, and misalignment detection.
module mem_align
  import common::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  mem_size,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection from the addressed byte/halfword of the bus word
  always_comb begin
    byte_lane = rdata[{addr, 3'b000} +: 8];
    half_lane = rdata[{addr[1], 4'b0000} +: 16];
  end

  // Size decode; unsupported sizes are reported as misaligned
  always_comb begin
    be         = '0;
    wdata      = sdata;
    ldata      = rdata;
    misaligned = 1'b0;
    case (mem_size)
      SZ_B, SZ_BU: begin
        be    = 4'b0001 << addr;
        wdata = {4{sdata[7:0]}};
        ldata = (mem_size == SZ_B) ? {{24{byte_lane[7]}}, byte_lane}
                                   : {24'h0, byte_lane};
      end
      SZ_H, SZ_HU: begin
        be         = 4'b0011 << addr;
        wdata      = {2{sdata[15:0]}};
        ldata      = (mem_size == SZ_H) ? {{16{half_lane[15]}}, half_lane}
                                        : {16'h0, half_lane};
        misaligned = addr[0];
      end
      SZ_W: begin
        be         = 4'b1111;
        wdata      = sdata;
        ldata      = rdata;
        misaligned = (addr != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues data-memory loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding, and registers the writeback result.
module memory_stage
  import common::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid_in,
  input  logic [31:0]       alu_data_in,
  input  logic [31:0]       memory_data_in,
  input  control_type       control_in,
  input  logic              compflg_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output control_type       control_out,
  output logic              compflg_out,
  output logic              misaligned_exc,
  output logic              bus_error
);

  mem_state_t        state, state_next;
  logic [WAIT_W-1:0] wait_cnt, cnt_inc;
  logic [31:0]       addr_q, sdata_q;
  control_type       ctrl_q;
  logic              comp_q;

  logic              in_access, is_mem, accept_mem, timeout;
  logic [1:0]        al_addr;
  logic [2:0]        al_size;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_ldata;
  logic              al_mis;

  // One aligner serves both the incoming op (IDLE) and the latched access (ACCESS)
  always_comb begin
    in_access  = (state == ACCESS);
    al_addr    = in_access ? addr_q[1:0] : alu_data_in[1:0];
    al_size    = in_access ? ctrl_q.mem_size : control_in.mem_size;
    is_mem     = control_in.mem_read | control_in.mem_write;
    accept_mem = (state == IDLE) && instr_valid_in && is_mem && !al_mis;
    cnt_inc    = wait_cnt + WAIT_W'(1);
    timeout    = in_access && !dmem_ack && (cnt_inc == WAIT_W'(MAX_WAIT));
  end

  mem_align u_align (
    .addr       (al_addr),
    .mem_size   (al_size),
    .sdata      (in_access ? sdata_q : memory_data_in),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .ldata      (al_ldata),
    .misaligned (al_mis)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_mem) state_next = ACCESS;
      ACCESS:  if (dmem_ack || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus and stall outputs, driven only while an access is outstanding
  always_comb begin
    stall_out  = in_access;
    dmem_req   = in_access;
    dmem_we    = in_access & ctrl_q.mem_write;
    dmem_addr  = in_access ? {addr_q[31:2], 2'b00} : '0;
    dmem_be    = in_access ? al_be : '0;
    dmem_wdata = in_access ? al_wdata : '0;
  end

  // Wait counter: cleared on accept, counts ACCESS cycles without ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        wait_cnt <= '0;
    else if (accept_mem)            wait_cnt <= '0;
    else if (in_access && !dmem_ack) wait_cnt <= cnt_inc;
  end

  // Access latch, held stable for the whole bus transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      sdata_q <= '0;
      ctrl_q  <= '0;
      comp_q  <= 1'b0;
    end else if (accept_mem) begin
      addr_q  <= alu_data_in;
      sdata_q <= memory_data_in;
      ctrl_q  <= control_in;
      comp_q  <= compflg_in;
    end
  end

  // Writeback registers; valid and exception flags are single-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid       <= 1'b0;
      wb_data        <= '0;
      control_out    <= '0;
      compflg_out    <= 1'b0;
      misaligned_exc <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      misaligned_exc <= 1'b0;
      bus_error      <= 1'b0;
      if (state == IDLE) begin
        if (instr_valid_in && (!is_mem || al_mis)) begin
          wb_valid    <= 1'b1;
          wb_data     <= alu_data_in;
          control_out <= control_in;
          compflg_out <= compflg_in;
          if (is_mem) begin
            misaligned_exc        <= 1'b1;
            control_out.reg_write <= 1'b0;
          end
        end
      end else if (dmem_ack || timeout) begin
        wb_valid    <= 1'b1;
        wb_data     <= (dmem_ack && ctrl_q.mem_read) ? al_ldata : addr_q;
        control_out <= ctrl_q;
        compflg_out <= comp_q;
        if (!dmem_ack) begin
          bus_error             <= 1'b1;
          control_out.reg_write <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, loads, stores, misalignment,
// timeout, ack-at-limit, and asynchronous reset during an access.
module tb_memory_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid_in = 1'b0;
  logic [31:0] alu_data_in = '0;
  logic [31:0] memory_data_in = '0;
  control_type control_in = '0;
  logic        compflg_in = 1'b0;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  control_type control_out;
  logic        compflg_out, misaligned_exc, bus_error;

  int errors = 0;
  int checks = 0;

  memory_stage #(.MAX_WAIT(15), .WAIT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid_in (instr_valid_in),
    .alu_data_in    (alu_data_in),
    .memory_data_in (memory_data_in),
    .control_in     (control_in),
    .compflg_in     (compflg_in),
    .stall_out      (stall_out),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_data        (wb_data),
    .control_out    (control_out),
    .compflg_out    (compflg_out),
    .misaligned_exc (misaligned_exc),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic control_type mk(input logic rw, input logic mr, input logic mw,
                                     input logic [2:0] sz);
    control_type c;
    c.rd        = 5'd7;
    c.reg_write = rw;
    c.mem_read  = mr;
    c.mem_write = mw;
    c.mem_size  = sz;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input control_type c, input logic [31:0] a, input logic [31:0] d);
    instr_valid_in = 1'b1;
    control_in     = c;
    alu_data_in    = a;
    memory_data_in = d;
  endtask

  // Load with ack in the first ACCESS cycle
  task automatic load1(input string tag, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] rdata, input logic [3:0] exp_be,
                       input logic [31:0] exp_data);
    issue(mk(1'b1, 1'b1, 1'b0, sz), addr, 32'h0);
    step();
    instr_valid_in = 1'b0;
    check({tag, "_req"}, dmem_req, 1);
    check({tag, "_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
    check({tag, "_be"}, dmem_be, exp_be);
    check({tag, "_we"}, dmem_we, 0);
    check({tag, "_wbv_pending"}, wb_valid, 0);
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    step();
    dmem_ack = 1'b0;
    check({tag, "_wbv"}, wb_valid, 1);
    check({tag, "_data"}, wb_data, exp_data);
    check({tag, "_stall"}, stall_out, 0);
  endtask

  initial begin
    int req_cycles;

    // Reset state
    @(negedge clk);
    check("rst_wbv", wb_valid, 0);
    check("rst_stall", stall_out, 0);
    check("rst_req", dmem_req, 0);
    check("rst_be", dmem_be, 0);
    check("rst_ctrl", control_out, 0);
    check("rst_wbdata", wb_data, 0);
    rst = 1'b0;
    step();

    // ALU result passes through with latency 1
    issue(mk(1'b1, 1'b0, 1'b0, SZ_W), 32'h0000_1234, 32'h0);
    compflg_in = 1'b1;
    check("add_stall", stall_out, 0);
    step();
    instr_valid_in = 1'b0;
    compflg_in     = 1'b0;
    check("add_wbv", wb_valid, 1);
    check("add_data", wb_data, 32'h0000_1234);
    check("add_rw", control_out.reg_write, 1);
    check("add_comp", compflg_out, 1);
    check("add_stall2", stall_out, 0);
    step();
    check("idle_wbv", wb_valid, 0);
    check("idle_hold", wb_data, 32'h0000_1234);

    // Loads with extension
    load1("lb",  SZ_B,  32'h103, 32'h80AA_BBCC, 4'b1000, 32'hFFFF_FF80);
    load1("lbu", SZ_BU, 32'h103, 32'h80AA_BBCC, 4'b1000, 32'h0000_0080);
    load1("lh",  SZ_H,  32'h102, 32'h80AA_BBCC, 4'b1100, 32'hFFFF_80AA);
    load1("lhu", SZ_HU, 32'h100, 32'h80AA_BBCC, 4'b0011, 32'h0000_BBCC);
    load1("lb1", SZ_B,  32'h101, 32'h80AA_BBCC, 4'b0010, 32'hFFFF_FFBB);
    load1("lw",  SZ_W,  32'h104, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);

    // Store halfword, ack on third ACCESS cycle, inputs changed mid-access
    issue(mk(1'b0, 1'b0, 1'b1, SZ_H), 32'h202, 32'h0000_BEEF);
    step();
    issue(mk(1'b1, 1'b1, 1'b0, SZ_B), 32'hDEAD_0001, 32'h1111_2222);
    for (int i = 0; i < 3; i++) begin
      check("sh_stall", stall_out, 1);
      check("sh_be", dmem_be, 4'b1100);
      check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
      check("sh_addr", dmem_addr, 32'h200);
      check("sh_we", dmem_we, 1);
      if (i == 2) dmem_ack = 1'b1;
      step();
    end
    dmem_ack       = 1'b0;
    instr_valid_in = 1'b0;
    check("sh_wbv", wb_valid, 1);
    check("sh_data", wb_data, 32'h202);
    check("sh_rw", control_out.reg_write, 0);
    check("sh_stall_end", stall_out, 0);
    step();
    check("sh_wbv_pulse", wb_valid, 0);

    // Misaligned word load: no bus request
    issue(mk(1'b1, 1'b1, 1'b0, SZ_W), 32'h301, 32'h0);
    check("mis_req", dmem_req, 0);
    step();
    instr_valid_in = 1'b0;
    check("mis_wbv", wb_valid, 1);
    check("mis_exc", misaligned_exc, 1);
    check("mis_rw", control_out.reg_write, 0);
    check("mis_req2", dmem_req, 0);
    step();
    check("mis_clear", misaligned_exc, 0);

    // Misaligned halfword and unsupported size
    issue(mk(1'b1, 1'b1, 1'b0, SZ_H), 32'h101, 32'h0);
    step();
    check("mish_exc", misaligned_exc, 1);
    issue(mk(1'b1, 1'b1, 1'b0, 3'b011), 32'h100, 32'h0);
    step();
    instr_valid_in = 1'b0;
    check("unsup_exc", misaligned_exc, 1);
    check("unsup_stall", stall_out, 0);
    step();

    // Timeout: no ack, next instruction held upstream
    issue(mk(1'b1, 1'b1, 1'b0, SZ_W), 32'h400, 32'h0);
    step();
    issue(mk(1'b1, 1'b0, 1'b0, SZ_W), 32'h55, 32'h0);
    req_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (dmem_req !== 1'b1) break;
      req_cycles++;
      step();
    end
    check("to_cycles", req_cycles, 15);
    check("to_wbv", wb_valid, 1);
    check("to_err", bus_error, 1);
    check("to_rw", control_out.reg_write, 0);
    check("to_req", dmem_req, 0);
    step();
    instr_valid_in = 1'b0;
    check("b2b_wbv", wb_valid, 1);
    check("b2b_data", wb_data, 32'h55);
    check("b2b_err", bus_error, 0);
    step();

    // Ack coinciding with the wait limit: ack wins
    issue(mk(1'b1, 1'b1, 1'b0, SZ_W), 32'h500, 32'h0);
    step();
    instr_valid_in = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("edge_req", dmem_req, 1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1234_5678;
    step();
    dmem_ack = 1'b0;
    check("edge_wbv", wb_valid, 1);
    check("edge_err", bus_error, 0);
    check("edge_data", wb_data, 32'h1234_5678);
    check("edge_rw", control_out.reg_write, 1);
    step();

    // Asynchronous reset during an access
    issue(mk(1'b1, 1'b1, 1'b0, SZ_W), 32'h600, 32'h0);
    step();
    instr_valid_in = 1'b0;
    check("ra_req", dmem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("ra_req0", dmem_req, 0);
    check("ra_stall0", stall_out, 0);
    check("ra_wbv0", wb_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(mk(1'b1, 1'b0, 1'b0, SZ_W), 32'h77, 32'h0);
    step();
    instr_valid_in = 1'b0;
    check("ra_add_wbv", wb_valid, 1);
    check("ra_add_data", wb_data, 32'h77);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage directly downstream of the execute stage. Consumes the execute-stage results (ALU result as address or data, store data, control word, valid, compressed flag).
- Performs data-memory loads and stores over a req/ack bus, with byte-lane alignment and load sign/zero extension.
- Presents a registered writeback result to the writeback stage.
- Stalls upstream while a memory access is outstanding.

Parameters:
MAX_WAIT, 15, cycles in ACCESS without dmem_ack before the access is abandoned with bus_error (1..255)
WAIT_W, 8, width of the wait counter; must hold MAX_WAIT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid_in  in  1  execute result valid
alu_data_in  in  32  ALU result: memory address for loads/stores, writeback value otherwise
memory_data_in  in  32  store data (rs2)
control_in  in  control_type  common::control_type; fields used: mem_read, mem_write, mem_size (funct3), reg_write
compflg_in  in  1  compressed-instruction flag, passed through
stall_out  out  1  upstream must hold its outputs while 1
dmem_req  out  1  memory request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  request completed this cycle
dmem_rdata  in  32  load data, valid with dmem_ack
wb_valid  out  1  writeback result valid (one-cycle pulse per instruction)
wb_data  out  32  loaded/extended data or ALU result
control_out  out  control_type  registered control; reg_write forced 0 on exception
compflg_out  out  1  registered compressed flag
misaligned_exc  out  1  valid with wb_valid: access misaligned, no bus request issued
bus_error  out  1  valid with wb_valid: MAX_WAIT expired

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; wait counter 0; control_out all-zero.
- FSM states: IDLE, ACCESS.
- IDLE, instr_valid_in=1:
  - Non-memory op (mem_read=mem_write=0): next edge wb_valid=1, wb_data=alu_data_in, control/compflg registered. Latency 1.
  - Memory op, misaligned: next edge wb_valid=1, misaligned_exc=1, control_out.reg_write=0, no dmem_req. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Memory op, aligned: latch address, be, wdata, and control; go to ACCESS; wb_valid=0.
- IDLE, instr_valid_in=0: wb_valid=0 next edge; other registered outputs hold.
- ACCESS:
  - dmem_req=1, stall_out=1; dmem_* stable until ack or timeout.
  - dmem_ack=1: next edge → IDLE, wb_valid=1; loads: wb_data = extended lane; stores: wb_data=alu_data_in latched, reg_write as given.
  - Counter increments each ACCESS cycle without ack. Counter reaching MAX_WAIT with no ack: next edge → IDLE, dmem_req drops, wb_valid=1, bus_error=1, reg_write forced 0.
  - Ack on the same cycle as the counter reaches MAX_WAIT: ack wins, no error.
- stall_out = (state==ACCESS), combinational from state. Upstream holds the next instruction during the stall; it is accepted in the first IDLE cycle after. Minimum memory-op latency is 2 edges (ack in first ACCESS cycle).
- Inputs are ignored in ACCESS.
- Byte enables, with a = addr[1:0]:
  - Byte: 4'b0001<<a.
  - Half: 4'b0011<<a.
  - Word: 4'b1111.
- Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load extension: select lane by a.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW direct.
  - Unsupported mem_size on a memory op is treated as misaligned.
- misaligned_exc and bus_error are 0 whenever wb_valid=0.
- Reset asserted mid-ACCESS: dmem_req drops immediately (async); transaction abandoned; no wb_valid.

Decomposition:
- Package common: control_type (existing). Add mem_size encodings SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101, and the state enum mem_state_t {IDLE, ACCESS}.
- Sub-module mem_align: purely combinational. Inputs addr[1:0], mem_size, store data, rdata. Outputs be, wdata, extended load data, misaligned.
- The FSM, counter, and output registers stay in memory_stage.

Test Plan:
- ADD result alu_data_in=0x0000_1234, mem_read=mem_write=0 → next edge wb_valid=1, wb_data=0x0000_1234, stall_out never 1.
- LB addr 0x103, rdata 0x80AA_BBCC, ack in first ACCESS cycle → dmem_addr=0x100, be=4'b1000, wb_data=0xFFFF_FF80 two edges after accept; LBU same → 0x0000_0080.
- SH addr 0x202, data 0x0000_BEEF, ack after 3 cycles → be=4'b1100, wdata=0xBEEF_BEEF, dmem_we=1, stall_out=1 for 3 cycles, then wb_valid pulse.
- LW addr 0x301 → no dmem_req, wb_valid=1, misaligned_exc=1, control_out.reg_write=0 after 1 edge.
- LW with ack never asserted, MAX_WAIT=15 → dmem_req high 15 cycles, then wb_valid=1, bus_error=1, reg_write=0; back-to-back next instruction accepted the following cycle.
- rst pulsed while in ACCESS → dmem_req, stall_out, wb_valid all 0 immediately; after release, a new ADD completes with latency 1.
